// File: rtl/decoder_pkg.sv
// Shared definitions for select-line decoders:
// mode encodings, state enum and the one-hot helper.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned MAX_OUT_N = 256;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  // Callers truncate the result to their own output width.
  function automatic logic [MAX_OUT_N-1:0] onehot_decode(
    input int unsigned sel,
    input int unsigned n,
    input bit          msb_first
  );
    logic [MAX_OUT_N-1:0] r;
    int unsigned pos;
    r   = '0;
    pos = msb_first ? (n - 1 - sel) : sel;
    for (int unsigned i = 0; i < MAX_OUT_N; i++) begin
      r[i] = (i < n) && (i == pos);
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_scan_prescaler.sv
// Scan prescaler: counts cycles while running and
// strobes an advance when the count reaches div.
import decoder_pkg::*;

module scan_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             adv
);

  logic [DIV_W-1:0] cnt;

  assign adv = run && (cnt == div);

  // A count above div keeps going and wraps at DIV_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !run || adv) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot select driver with
// direct-load and prescaled auto-scan modes.
import decoder_pkg::*;

module onehot_scan_decoder #(
  parameter int SEL_W     = 2,
  parameter int MSB_FIRST = 1,
  parameter int DIV_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                load_valid,
  input  logic [SEL_W-1:0]    load_idx,
  output logic                load_ready,
  input  logic [DIV_W-1:0]    div,
  input  logic [SEL_W-1:0]    scan_last,
  output logic [SEL_W-1:0]    idx,
  output logic [2**SEL_W-1:0] y,
  output logic                tick,
  output logic                wrap
);

  localparam int OUT_N = 2**SEL_W;

  state_t           st;
  logic             accept;
  logic             run;
  logic             adv;
  logic [SEL_W-1:0] idx_d;
  logic [OUT_N-1:0] y_d;
  logic             tick_d;
  logic             wrap_d;

  assign load_ready = en;
  assign accept     = load_valid && en;
  assign run        = (st == SCAN);

  scan_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clear(accept),
    .div  (div),
    .adv  (adv)
  );

  always_comb begin
    st = OFF;
    unique case (1'b1)
      !en:                        st = OFF;
      en && mode == MODE_DIRECT:  st = HOLD;
      en && mode == MODE_SCAN:    st = SCAN;
      default:                    st = OFF;
    endcase
  end

  // A load always beats a coincident scan advance.
  always_comb begin
    idx_d  = idx;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    unique case (st)
      HOLD: begin
        if (accept) idx_d = load_idx;
      end
      SCAN: begin
        if (accept) begin
          idx_d = load_idx;
        end else if (adv) begin
          tick_d = 1'b1;
          if (idx >= scan_last) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      default: ;
    endcase
    y_d = '0;
    if (en) begin
      y_d = OUT_N'(onehot_decode(32'(idx_d), OUT_N,
                                 MSB_FIRST != 0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      y    <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      idx  <= idx_d;
      y    <= y_d;
      tick <= tick_d;
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Bench for onehot_scan_decoder: directed scenarios
// plus randomized traffic against a reference model.
module tb_onehot_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        load_valid = 1'b0;
  logic [1:0]  load_idx = '0;
  logic        load_ready;
  logic [15:0] div = '0;
  logic [1:0]  scan_last = 2'd3;
  logic [1:0]  idx;
  logic [3:0]  y;
  logic        tick;
  logic        wrap;

  logic        en8 = 1'b0;
  logic        mode8 = 1'b0;
  logic        lv8 = 1'b0;
  logic [2:0]  li8 = '0;
  logic        lr8;
  logic [2:0]  idx8;
  logic [7:0]  y8;
  logic        tick8;
  logic        wrap8;

  int total = 0;
  int bad = 0;

  // reference model state
  int          m_idx;
  logic [15:0] m_cnt;
  logic        m_en;
  logic        m_tick;
  logic        m_wrap;

  always #5 clk = ~clk;

  onehot_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .load_valid(load_valid), .load_idx(load_idx),
    .load_ready(load_ready), .div(div),
    .scan_last(scan_last), .idx(idx), .y(y),
    .tick(tick), .wrap(wrap)
  );

  onehot_scan_decoder #(
    .SEL_W(3), .MSB_FIRST(0), .DIV_W(16)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8),
    .load_valid(lv8), .load_idx(li8),
    .load_ready(lr8), .div(16'd0),
    .scan_last(3'd7), .idx(idx8), .y(y8),
    .tick(tick8), .wrap(wrap8)
  );

  task automatic model_reset();
    m_idx  = 0;
    m_cnt  = '0;
    m_en   = 1'b0;
    m_tick = 1'b0;
    m_wrap = 1'b0;
  endtask

  // Next-cycle expectation from the currently driven inputs.
  task automatic model_step();
    m_en   = en;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (!en) begin
      m_cnt = '0;
    end else if (load_valid) begin
      m_idx = int'(load_idx);
      m_cnt = '0;
    end else if (!mode) begin
      m_cnt = '0;
    end else if (m_cnt == div) begin
      m_cnt  = '0;
      m_tick = 1'b1;
      if (m_idx >= int'(scan_last)) begin
        m_idx  = 0;
        m_wrap = 1'b1;
      end else begin
        m_idx = m_idx + 1;
      end
    end else begin
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  function automatic logic [3:0] exp_y();
    logic [3:0] top;
    top = 4'b1000;
    return m_en ? (top >> m_idx) : 4'b0000;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    en = 1'b1; mode = 1'b1; div = 16'd0; scan_last = 2'd3;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (y !== 4'b0000 || idx !== 2'd0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: y=%b idx=%0d tick=%b want 0000/0/0",
               y, idx, tick);
    end
    mode = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    total++;
    if (y !== 4'b1000 || idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_release: y=%b idx=%0d want 1000/0", y, idx);
    end
  endtask

  task automatic test_direct();
    logic [3:0] want;
    en = 1'b1; mode = 1'b0; load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_idx = 2'(i);
      step();
      want = 4'b1000 >> i;
      total++;
      if (y !== want || idx !== 2'(i)) begin
        bad++;
        $display("FAIL direct_load%0d: y=%b idx=%0d want %b/%0d",
                 i, y, idx, want, i);
      end
    end
    load_valid = 1'b0;
    en = 1'b0;
    #1;
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL disabled_ready: got %b want 0", load_ready);
    end
    step();
    total++;
    if (y !== 4'b0000 || idx !== 2'd3) begin
      bad++;
      $display("FAIL disabled_y: y=%b idx=%0d want 0000/3", y, idx);
    end
  endtask

  task automatic test_scan_sweep();
    int ticks;
    int wraps;
    ticks = 0;
    wraps = 0;
    en = 1'b1; mode = 1'b0; load_valid = 1'b1; load_idx = 2'd0;
    step();
    load_valid = 1'b0; mode = 1'b1; div = 16'd2; scan_last = 2'd3;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (tick === 1'b1) ticks++;
      if (wrap === 1'b1) wraps++;
      total++;
      if (idx !== 2'((n / 3) % 4) || tick !== (n % 3 == 0)) begin
        bad++;
        $display("FAIL sweep_c%0d: idx=%0d tick=%b want %0d/%b",
                 n, idx, tick, (n / 3) % 4, n % 3 == 0);
      end
    end
    total++;
    if (ticks != 4 || wraps != 1) begin
      bad++;
      $display("FAIL sweep_pulses: ticks=%0d wraps=%0d want 4/1",
               ticks, wraps);
    end
  endtask

  task automatic test_bounded();
    div = 16'd0; scan_last = 2'd1;
    for (int n = 1; n <= 6; n++) begin
      step();
      total++;
      if (idx !== 2'(n % 2)) begin
        bad++;
        $display("FAIL bounded_c%0d: idx=%0d want %0d", n, idx, n % 2);
      end
    end
    load_valid = 1'b1; load_idx = 2'd3;
    step();
    total++;
    if (y !== 4'b0001 || tick !== 1'b0) begin
      bad++;
      $display("FAIL oor_load: y=%b tick=%b want 0001/0", y, tick);
    end
    load_valid = 1'b0;
    step();
    total++;
    if (idx !== 2'd0 || wrap !== 1'b1 || y !== 4'b1000) begin
      bad++;
      $display("FAIL oor_wrap: idx=%0d wrap=%b y=%b want 0/1/1000",
               idx, wrap, y);
    end
  endtask

  task automatic test_collision();
    mode = 1'b0; load_valid = 1'b1; load_idx = 2'd0;
    step();
    load_valid = 1'b0; mode = 1'b1; div = 16'd3; scan_last = 2'd3;
    repeat (3) step();
    load_valid = 1'b1; load_idx = 2'd2;
    step();
    total++;
    if (idx !== 2'd2 || tick !== 1'b0) begin
      bad++;
      $display("FAIL collide_load: idx=%0d tick=%b want 2/0", idx, tick);
    end
    load_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
      total++;
      if (tick !== (n == 4) || idx !== (n == 4 ? 2'd3 : 2'd2)) begin
        bad++;
        $display("FAIL collide_c%0d: tick=%b idx=%0d want %b/%0d",
                 n, tick, idx, n == 4, n == 4 ? 3 : 2);
      end
    end
  endtask

  task automatic test_width();
    en8 = 1'b1; mode8 = 1'b0; lv8 = 1'b1; li8 = 3'd5;
    step();
    total++;
    if (y8 !== 8'b0010_0000 || idx8 !== 3'd5) begin
      bad++;
      $display("FAIL w8_load: y=%b idx=%0d want 00100000/5", y8, idx8);
    end
    lv8 = 1'b0; en8 = 1'b0;
    step();
    total++;
    if (y8 !== 8'b0 || lr8 !== 1'b0) begin
      bad++;
      $display("FAIL w8_off: y=%b ready=%b want 0/0", y8, lr8);
    end
    en8 = 1'b1;
    step();
    total++;
    if (y8 !== 8'b0010_0000 || idx8 !== 3'd5) begin
      bad++;
      $display("FAIL w8_reen: y=%b idx=%0d want 00100000/5", y8, idx8);
    end
  endtask

  task automatic test_random();
    logic [3:0] want;
    en = 1'b0; load_valid = 1'b0; mode = 1'b0;
    div = 16'd1; scan_last = 2'd3;
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      en         = ($urandom_range(0, 7) != 0);
      mode       = ($urandom_range(0, 3) != 0);
      load_valid = ($urandom_range(0, 9) == 0);
      load_idx   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) div = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) scan_last = 2'($urandom_range(0, 3));
      #1;
      total++;
      if (load_ready !== en) begin
        bad++;
        $display("FAIL rnd_ready%0d: got %b want %b", n, load_ready, en);
      end
      step();
      want = exp_y();
      total++;
      if (idx !== 2'(m_idx) || y !== want ||
          tick !== m_tick || wrap !== m_wrap) begin
        bad++;
        $display("FAIL rnd_c%0d: idx=%0d y=%b t=%b w=%b want %0d/%b/%b/%b",
                 n, idx, y, tick, wrap, m_idx, want, m_tick, m_wrap);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_direct();
    test_scan_sweep();
    test_bounded();
    test_collision();
    test_width();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
